// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle for the EXU and LSU requesters.
// Carries valid/rd/data from each requester and the per-requester ready.
interface regfile_wb_arbiter_if #(
    parameter int XLEN = 32
);
    logic            ExuValid;
    logic [4:0]      ExuRd;
    logic [XLEN-1:0] ExuData;
    logic            ExuReady;
    logic            LsuValid;
    logic [4:0]      LsuRd;
    logic [XLEN-1:0] LsuData;
    logic            LsuReady;

    modport master (
        output ExuValid, ExuRd, ExuData,
        output LsuValid, LsuRd, LsuData,
        input  ExuReady, LsuReady
    );

    modport slave (
        input  ExuValid, ExuRd, ExuData,
        input  LsuValid, LsuRd, LsuData,
        output ExuReady, LsuReady
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file write port plus busy scoreboard.
// Ports: clk, rst_n, wb (EXU/LSU requests), Issue*/Query*/Busy*, RegWEn/AddrD/DataD.
module regfile_wb_arbiter #(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  wb,
    input  logic                 IssueValid,
    input  logic [4:0]           IssueRd,
    input  logic [4:0]           QueryA,
    input  logic [4:0]           QueryB,
    output logic                 BusyA,
    output logic                 BusyB,
    output logic                 RegWEn,
    output logic [4:0]           AddrD,
    output logic [XLEN-1:0]      DataD
);

    logic            ptr_q, ptr_d;
    logic            regwen_q, regwen_d;
    logic [4:0]      addr_q, addr_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [31:0]     busy_q, busy_d;
    logic            gnt_exu, gnt_lsu;

    // Grants are masked during reset so nothing is accepted then.
    always_comb begin
        gnt_exu = 1'b0;
        gnt_lsu = 1'b0;
        if (rst_n) begin
            if (wb.ExuValid && wb.LsuValid) begin
                gnt_exu = !ptr_q;
                gnt_lsu = ptr_q;
            end else begin
                gnt_exu = wb.ExuValid;
                gnt_lsu = wb.LsuValid;
            end
        end
    end

    assign wb.ExuReady = gnt_exu;
    assign wb.LsuReady = gnt_lsu;

    always_comb begin
        ptr_d    = ptr_q;
        regwen_d = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        if (gnt_exu) begin
            ptr_d    = 1'b1;
            regwen_d = (wb.ExuRd != 5'd0);
            addr_d   = wb.ExuRd;
            data_d   = wb.ExuData;
        end else if (gnt_lsu) begin
            ptr_d    = 1'b0;
            regwen_d = (wb.LsuRd != 5'd0);
            addr_d   = wb.LsuRd;
            data_d   = wb.LsuData;
        end
    end

    // Clear first, then set, so an issue to the register being
    // written back in the same cycle keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (regwen_q) begin
            busy_d[addr_q] = 1'b0;
        end
        if (IssueValid && (IssueRd != 5'd0)) begin
            busy_d[IssueRd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= 1'b0;
            regwen_q <= 1'b0;
            addr_q   <= 5'd0;
            data_q   <= '0;
            busy_q   <= 32'd0;
        end else begin
            ptr_q    <= ptr_d;
            regwen_q <= regwen_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
        end
    end

    assign RegWEn = regwen_q;
    assign AddrD  = addr_q;
    assign DataD  = data_q;
    assign BusyA  = busy_q[QueryA];
    assign BusyB  = busy_q[QueryB];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed vector table plus random run.
// Random phase is checked against a behavioural model of the spec rules.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        IssueValid;
    logic [4:0]  IssueRd;
    logic [4:0]  QueryA, QueryB;
    logic        BusyA, BusyB;
    logic        RegWEn;
    logic [4:0]  AddrD;
    logic [31:0] DataD;

    regfile_wb_arbiter_if #(.XLEN(32)) wb ();

    regfile_wb_arbiter #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb         (wb),
        .IssueValid (IssueValid),
        .IssueRd    (IssueRd),
        .QueryA     (QueryA),
        .QueryB     (QueryB),
        .BusyA      (BusyA),
        .BusyB      (BusyB),
        .RegWEn     (RegWEn),
        .AddrD      (AddrD),
        .DataD      (DataD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ev;
        logic [4:0]  erd;
        logic [31:0] ed;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  qa;
        logic [4:0]  qb;
        logic        xer;
        logic        xlr;
        logic        xwe;
        logic [4:0]  xaddr;
        logic [31:0] xdata;
        logic        xba;
        logic        xbb;
    } vec_t;

    vec_t vt[14];

    // Behavioural model: who owns the next tie, which registers have
    // a write outstanding, and what the register file port shows.
    typedef enum int { NONE, EXU, LSU } who_t;
    who_t        tie_winner;
    bit          pending_write[32];
    bit          port_we;
    logic [4:0]  port_addr;
    logic [31:0] port_data;

    function automatic who_t pick(input logic ev, input logic lv);
        if (ev && lv) return tie_winner;
        if (ev) return EXU;
        if (lv) return LSU;
        return NONE;
    endfunction

    task automatic model_reset();
        tie_winner = EXU;
        foreach (pending_write[i]) pending_write[i] = 1'b0;
        port_we   = 1'b0;
        port_addr = 5'd0;
        port_data = 32'd0;
    endtask

    task automatic model_edge(input who_t w);
        if (port_we) pending_write[port_addr] = 1'b0;
        if (IssueValid && IssueRd != 0) pending_write[IssueRd] = 1'b1;
        port_we = 1'b0;
        if (w == EXU) begin
            port_we    = (wb.ExuRd != 0);
            port_addr  = wb.ExuRd;
            port_data  = wb.ExuData;
            tie_winner = LSU;
        end else if (w == LSU) begin
            port_we    = (wb.LsuRd != 0);
            port_addr  = wb.LsuRd;
            port_data  = wb.LsuData;
            tie_winner = EXU;
        end
    endtask

    function automatic logic [63:0] dut_vec();
        return {22'd0, wb.ExuReady, wb.LsuReady, RegWEn, AddrD, DataD,
                BusyA, BusyB};
    endfunction

    function automatic logic [63:0] model_vec(input who_t w);
        return {22'd0, logic'(w == EXU), logic'(w == LSU), logic'(port_we),
                port_addr, port_data,
                logic'(pending_write[QueryA]), logic'(pending_write[QueryB])};
    endfunction

    logic ev_r, lv_r;
    logic [4:0] erd_r, lrd_r;
    logic [31:0] ed_r, ld_r;

    task automatic rand_cycle(input string name);
        who_t w;
        wb.ExuValid = ev_r; wb.ExuRd = erd_r; wb.ExuData = ed_r;
        wb.LsuValid = lv_r; wb.LsuRd = lrd_r; wb.LsuData = ld_r;
        IssueValid = ($urandom_range(0, 2) == 0);
        IssueRd    = 5'($urandom_range(0, 7));
        QueryA     = 5'($urandom_range(0, 7));
        QueryB     = 5'($urandom_range(0, 7));
        w = pick(ev_r, lv_r);
        @(negedge clk);
        check(name, dut_vec(), model_vec(w));
        model_edge(w);
        // A requester that was not accepted keeps its request stable.
        if (!ev_r || w == EXU) begin
            ev_r  = ($urandom_range(0, 2) != 0);
            erd_r = 5'($urandom_range(0, 7));
            ed_r  = $urandom;
        end
        if (!lv_r || w == LSU) begin
            lv_r  = ($urandom_range(0, 2) != 0);
            lrd_r = 5'($urandom_range(0, 7));
            ld_r  = $urandom;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0]  = '{1,5,32'hDEADBEEF, 0,0,0, 0,0, 5,0, 1,0,0,0,0,0,0};
        vt[1]  = '{0,0,0, 0,0,0, 1,7, 7,5, 0,0,1,5,32'hDEADBEEF,0,0};
        vt[2]  = '{1,1,32'h11, 1,9,32'h99, 0,0, 7,0,
                   0,1,0,5,32'hDEADBEEF,1,0};
        vt[3]  = '{1,1,32'h11, 1,9,32'h9A, 0,0, 7,0, 1,0,1,9,32'h99,1,0};
        vt[4]  = '{1,2,32'h22, 1,9,32'h9A, 0,0, 7,0, 0,1,1,1,32'h11,1,0};
        vt[5]  = '{0,0,0, 1,7,32'h77, 1,3, 7,3, 0,1,1,9,32'h9A,1,0};
        vt[6]  = '{0,0,0, 0,0,0, 0,0, 7,3, 0,0,1,7,32'h77,1,1};
        vt[7]  = '{0,0,0, 0,0,0, 0,0, 7,3, 0,0,0,7,32'h77,0,1};
        vt[8]  = '{1,3,32'h33, 0,0,0, 0,0, 7,3, 1,0,0,7,32'h77,0,1};
        vt[9]  = '{0,0,0, 0,0,0, 1,3, 0,3, 0,0,1,3,32'h33,0,1};
        vt[10] = '{0,0,0, 0,0,0, 0,0, 0,3, 0,0,0,3,32'h33,0,1};
        vt[11] = '{1,0,32'h55, 0,0,0, 1,0, 0,3, 1,0,0,3,32'h33,0,1};
        vt[12] = '{1,6,32'h66, 1,4,32'h44, 0,0, 0,3,
                   0,1,0,0,32'h55,0,1};
        vt[13] = '{1,6,32'h66, 0,0,0, 0,0, 0,3, 1,0,1,4,32'h44,0,1};

        rst_n = 1'b0;
        wb.ExuValid = 1'b1; wb.ExuRd = 5'd5; wb.ExuData = 32'hDEADBEEF;
        wb.LsuValid = 1'b0; wb.LsuRd = 5'd0; wb.LsuData = 32'd0;
        IssueValid = 1'b0; IssueRd = 5'd0;
        QueryA = 5'd5; QueryB = 5'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_exu_ready", 64'(wb.ExuReady), 64'd0);
        check("reset_regwen", 64'(RegWEn), 64'd0);
        check("reset_addr", 64'(AddrD), 64'd0);
        check("reset_data", 64'(DataD), 64'd0);
        check("reset_busya", 64'(BusyA), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            wb.ExuValid = vt[i].ev;
            wb.ExuRd    = vt[i].erd;
            wb.ExuData  = vt[i].ed;
            wb.LsuValid = vt[i].lv;
            wb.LsuRd    = vt[i].lrd;
            wb.LsuData  = vt[i].ld;
            IssueValid  = vt[i].iv;
            IssueRd     = vt[i].ird;
            QueryA      = vt[i].qa;
            QueryB      = vt[i].qb;
            @(negedge clk);
            check($sformatf("vec%0d", i), dut_vec(),
                  {22'd0, vt[i].xer, vt[i].xlr, vt[i].xwe, vt[i].xaddr,
                   vt[i].xdata, vt[i].xba, vt[i].xbb});
            @(posedge clk);
            #1;
        end

        rst_n = 1'b0;
        model_reset();
        ev_r = 1'b0; lv_r = 1'b0;
        erd_r = 5'd0; lrd_r = 5'd0; ed_r = 32'd0; ld_r = 32'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 400; i++) rand_cycle("rand");

        // Asynchronous reset in the middle of traffic.
        ev_r = 1'b1; lv_r = 1'b1;
        wb.ExuValid = 1'b1; wb.LsuValid = 1'b1;
        IssueValid = 1'b0;
        QueryA = 5'd1;
        for (int r = 1; r < 32; r++)
            if (pending_write[r]) QueryA = 5'(r);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_outputs",
              {59'd0, wb.ExuReady, wb.LsuReady, RegWEn, BusyA, BusyB},
              64'd0);
        check("midreset_port", {27'd0, AddrD, DataD}, 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) rand_cycle("rand_post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between two writeback requesters (EXU result, LSU load data) using round-robin arbitration, and keeps a 32-entry busy scoreboard for operand hazard checks. It sits between the execute/load-store units and the register file: it drives RegWEn/AddrD/DataD from a registered output stage and answers busy queries for the decode stage's two source operands.

## Interface
- XLEN, 32, data width of writeback data and DataD
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ExuValid  in  1  EXU writeback request
- ExuRd  in  5  EXU destination register
- ExuData  in  XLEN  EXU result
- ExuReady  out  1  EXU request accepted this cycle
- LsuValid  in  1  LSU writeback request
- LsuRd  in  5  LSU destination register
- LsuData  in  XLEN  LSU load data
- LsuReady  out  1  LSU request accepted this cycle
- IssueValid  in  1  an instruction with a destination issues this cycle
- IssueRd  in  5  destination of the issuing instruction
- QueryA, QueryB  in  5 each  source registers to check
- BusyA, BusyB  out  1 each  queried register has a pending write
- RegWEn  out  1  register file write enable (registered)
- AddrD  out  5  register file write address (registered)
- DataD  out  XLEN  register file write data (registered)

## Operation
- Arbitration, combinational each cycle:
  - only one Valid high -> that requester granted
  - both high -> requester selected by priority pointer granted; other gets Ready=0 and must hold request stable
  - neither -> no grant
- Ready = Valid && granted; exactly zero or one Ready high per cycle; Ready never high without its Valid.
- Priority pointer (1 bit, 0=EXU, 1=LSU): after any grant, points to the non-granted requester; unchanged on no-grant cycles. Reset value 0 (EXU).
- Output stage: on grant, next edge loads AddrD<=Rd, DataD<=Data, RegWEn<=(Rd!=0). No grant -> RegWEn<=0; AddrD/DataD hold.
- Rd=0 requests: accepted normally (Ready=1, pointer advances); RegWEn stays 0.
- Scoreboard busy[31:0], bit 0 hard-wired 0:
  - set: IssueValid && IssueRd!=0 -> busy[IssueRd]<=1
  - clear: RegWEn=1 -> busy[AddrD]<=0 at that edge
  - same register set and cleared at same edge -> set wins
- BusyA = busy[QueryA], BusyB = busy[QueryB], combinational; query of x0 returns 0. Busy stays 1 during the RegWEn cycle (register file not yet updated).
- No internal backpressure: output stage drains every cycle, so the arbiter never stalls a granted requester.

## Timing
- Reset (rst_n=0, asynchronous): RegWEn=0, AddrD=0, DataD=0, busy=0, pointer=0. ExuReady/LsuReady forced 0 while rst_n=0. BusyA/BusyB=0.
- Reset mid-operation: pending output-stage write discarded (RegWEn drops immediately), all busy bits cleared, requests presented during reset not accepted.
- Latency: request accepted at cycle N -> RegWEn/AddrD/DataD valid in N+1 -> register file holds value after edge ending N+1 -> busy bit reads 0 in N+2.
- Throughput: one writeback per cycle; back-to-back contention alternates EXU, LSU, EXU, ...
- Issue in cycle N -> BusyX reflects it from N+1.

## Test plan
- Reset: hold rst_n=0 with ExuValid=1 -> ExuReady=0, RegWEn=0, AddrD=0, DataD=0, BusyA=0; release -> first grant goes to EXU.
- Single EXU write: ExuValid=1, ExuRd=5, ExuData=0xDEADBEEF at cycle N -> ExuReady=1 at N; RegWEn=1, AddrD=5, DataD=0xDEADBEEF at N+1; RegWEn=0 at N+2.
- Contention: both valid for 4 cycles (EXU rd=1..4, LSU rd=9, held until accepted) starting after reset -> grants EXU, LSU, EXU, LSU; AddrD sequence 1, 9, 2, 9.
- Scoreboard: issue rd=7 at N, QueryA=7 -> BusyA=1 from N+1; LSU writes rd=7 accepted at M -> BusyA=1 at M+1, 0 at M+2.
- Set/clear collision: RegWEn=1, AddrD=3 and IssueValid=1, IssueRd=3 same cycle -> busy[3] stays 1.
- x0 handling: EXU write rd=0 -> ExuReady=1, RegWEn never asserted, pointer flips; IssueRd=0 -> BusyA for QueryA=0 remains 0.
